// File: rtl/mips_pkg.sv
// Shared MIPS definitions: opcode constants, fetch FSM encoding and the
// default reset PC used by the instruction fetch unit.
package mips_pkg;

    // Primary opcode field values (instr[31:26]) decoded by the control unit
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    // Fetch FSM: REQ waits for the memory word, HOLD presents it to decode
    typedef enum logic [0:0] {
        ST_REQ  = 1'b0,
        ST_HOLD = 1'b1
    } fetch_state_t;

    // Default PC loaded on reset (word aligned)
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/unidad_busqueda_if.sv
// Bus bundle between the fetch unit, instruction memory and decode.
//
// Handshakes:
//   imem side : req/ack. The fetch unit holds imem_req=1 with a stable
//               imem_addr until a cycle with imem_ack=1; imem_rdata is
//               taken in that cycle. imem_ack while imem_req=0 is ignored.
//   decode side: valid/ready. instr_valid=1 keeps instr stable; a transfer
//               happens in a cycle where instr_valid && instr_ready, and
//               branch/jump/zero are sampled only in that cycle.
interface unidad_busqueda_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    logic [31:0] instr;
    logic [5:0]  opcode;
    logic        instr_valid;
    logic        instr_ready;
    logic        branch;
    logic        jump;
    logic        zero;

    // Fetch unit view
    modport master (
        output imem_req, imem_addr, instr, opcode, instr_valid,
        input  imem_ack, imem_rdata, instr_ready, branch, jump, zero
    );

    // Memory / datapath view
    modport slave (
        input  imem_req, imem_addr, instr, opcode, instr_valid,
        output imem_ack, imem_rdata, instr_ready, branch, jump, zero
    );

endinterface

// File: rtl/calc_siguiente_pc.sv
// Next-PC selection: jump over taken branch over sequential pc+4.
// Purely combinational so a pipelined fetch can reuse it as-is.
module calc_siguiente_pc (
    input  logic [31:0] pc,
    input  logic [31:0] instr,
    input  logic        branch,
    input  logic        jump,
    input  logic        zero,
    output logic [31:0] pc_sig
);

    logic [31:0] pc4;
    logic [31:0] br_off;
    logic        unused_opcode;

    assign pc4    = pc + 32'd4;
    assign br_off = {{14{instr[15]}}, instr[15:0], 2'b00};

    // Opcode bits play no part in target computation
    assign unused_opcode = ^instr[31:26];

    // Jump keeps the 256 MB region of pc+4; branch offset is word-scaled
    always_comb begin
        pc_sig = pc4;
        if (jump) begin
            pc_sig = {pc4[31:28], instr[25:0], 2'b00};
        end else if (branch && zero) begin
            pc_sig = pc4 + br_off;
        end
    end

endmodule

// File: rtl/unidad_busqueda.sv
// Instruction fetch unit: owns the PC, fetches one word per req/ack
// transaction and holds it for decode until the valid/ready handshake,
// where the control-unit decision selects the next PC.
module unidad_busqueda
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic                clk,
    input  logic                rst,
    unidad_busqueda_if.master   bus,
    output logic [31:0]         pc,
    output logic [31:0]         retired,
    output fetch_state_t        estado
);

    fetch_state_t estado_q;
    fetch_state_t estado_d;
    logic [31:0]  pc_q;
    logic [31:0]  instr_q;
    logic [31:0]  retired_q;
    logic [31:0]  pc_sig;
    logic         take_word;
    logic         handshake;

    calc_siguiente_pc u_calc (
        .pc     (pc_q),
        .instr  (instr_q),
        .branch (bus.branch),
        .jump   (bus.jump),
        .zero   (bus.zero),
        .pc_sig (pc_sig)
    );

    // State register; reset always returns to REQ
    always_ff @(posedge clk) begin
        if (rst) begin
            estado_q <= ST_REQ;
        end else begin
            estado_q <= estado_d;
        end
    end

    // Next state: REQ leaves on ack, HOLD leaves on handshake
    always_comb begin
        estado_d = estado_q;
        case (estado_q)
            ST_REQ:  if (bus.imem_ack)    estado_d = ST_HOLD;
            ST_HOLD: if (bus.instr_ready) estado_d = ST_REQ;
            default: estado_d = ST_REQ;
        endcase
    end

    // Outputs and datapath enables; the request is masked while in reset
    always_comb begin
        bus.imem_req    = 1'b0;
        bus.instr_valid = 1'b0;
        take_word       = 1'b0;
        handshake       = 1'b0;
        case (estado_q)
            ST_REQ: begin
                bus.imem_req = ~rst;
                take_word    = bus.imem_ack;
            end
            ST_HOLD: begin
                bus.instr_valid = 1'b1;
                handshake       = bus.instr_ready;
            end
            default: begin
                bus.imem_req = 1'b0;
            end
        endcase
    end

    // PC, held instruction and retire counter; reset wins over ack/handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q      <= RESET_PC;
            instr_q   <= 32'd0;
            retired_q <= 32'd0;
        end else begin
            if (take_word) begin
                instr_q <= bus.imem_rdata;
            end
            if (handshake) begin
                pc_q      <= pc_sig;
                retired_q <= retired_q + 32'd1;
            end
        end
    end

    assign bus.imem_addr = pc_q;
    assign bus.instr     = instr_q;
    assign bus.opcode    = instr_q[31:26];
    assign pc            = pc_q;
    assign retired       = retired_q;
    assign estado        = estado_q;

endmodule

// File: tb/tb_unidad_busqueda.sv
// Bench for unidad_busqueda: directed fetch scenarios followed by random
// fetches, checked cycle by cycle against an address-level reference model.
module tb_unidad_busqueda;
    import mips_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT ----------------
    unidad_busqueda_if bus ();
    logic [31:0]  pc;
    logic [31:0]  retired;
    fetch_state_t estado;

    unidad_busqueda #(.RESET_PC(32'h0000_0000)) u_dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .pc      (pc),
        .retired (retired),
        .estado  (estado)
    );

    // Standalone next-PC block for regions the top cannot reach quickly
    logic [31:0] c_pc;
    logic [31:0] c_instr;
    logic        c_br;
    logic        c_jp;
    logic        c_z;
    logic [31:0] c_next;

    calc_siguiente_pc u_calc (
        .pc     (c_pc),
        .instr  (c_instr),
        .branch (c_br),
        .jump   (c_jp),
        .zero   (c_z),
        .pc_sig (c_next)
    );

    // ---------------- scoreboard ----------------
    logic [31:0] exp_q[$];
    logic [31:0] m_pc;
    logic [31:0] m_ret;
    int          n_checks;
    int          n_errors;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Reference next-PC, written from the instruction-set rules
    function automatic logic [31:0] model_next(input logic [31:0] p, input logic [31:0] w,
                                               input logic b, input logic j, input logic z);
        logic [31:0] p4;
        int          off;
        p4 = p + 32'd4;
        if (j) return (p4 / 32'h1000_0000) * 32'h1000_0000 + (w % 32'h0400_0000) * 32'd4;
        if (b && z) begin
            off = int'($signed(w[15:0]));
            return p4 + 32'(off * 4);
        end
        return p4;
    endfunction

    // ---------------- driver tasks ----------------
    // One complete instruction: 'delay' cycles without ack, then ack; then
    // 'hold' cycles with ready low, then the handshake with the given flags.
    task automatic fetch_one(input int delay, input int hold, input logic [31:0] word,
                             input logic br, input logic jp, input logic z);
        for (int i = 0; i <= delay; i++) begin
            @(negedge clk);
            if (i == 0 && exp_q.size() > 0) m_pc = exp_q.pop_front();
            check("req_in_req",   32'(bus.imem_req),    32'd1);
            check("addr",         bus.imem_addr,        m_pc);
            check("valid_in_req", 32'(bus.instr_valid), 32'd0);
            check("retired_req",  retired,              m_ret);
            bus.imem_ack    = (i == delay);
            bus.imem_rdata  = (i == delay) ? word : $urandom();
            bus.instr_ready = 1'($urandom_range(0, 1));
            bus.branch      = 1'($urandom_range(0, 1));
            bus.jump        = 1'($urandom_range(0, 1));
            bus.zero        = 1'($urandom_range(0, 1));
        end
        for (int j = 0; j <= hold; j++) begin
            @(negedge clk);
            check("valid_hold",   32'(bus.instr_valid), 32'd1);
            check("req_in_hold",  32'(bus.imem_req),    32'd0);
            check("instr",        bus.instr,            word);
            check("opcode",       32'(bus.opcode),      32'(word[31:26]));
            check("pc_hold",      pc,                   m_pc);
            check("retired_hold", retired,              m_ret);
            bus.instr_ready = (j == hold);
            bus.imem_ack    = 1'($urandom_range(0, 1));
            bus.imem_rdata  = $urandom();
            bus.branch      = (j == hold) ? br : 1'($urandom_range(0, 1));
            bus.jump        = (j == hold) ? jp : 1'($urandom_range(0, 1));
            bus.zero        = (j == hold) ? z  : 1'($urandom_range(0, 1));
        end
        exp_q.push_back(model_next(m_pc, word, br, jp, z));
        m_ret = m_ret + 32'd1;
    endtask

    // Reset asserted while a request is outstanding, plus a late ack
    task automatic reset_in_req();
        @(negedge clk);
        if (exp_q.size() > 0) m_pc = exp_q.pop_front();
        check("pre_rst_req",  32'(bus.imem_req), 32'd1);
        check("pre_rst_addr", bus.imem_addr,     m_pc);
        bus.imem_ack = 1'b0;
        rst          = 1'b1;
        @(negedge clk);
        check("rst_req",     32'(bus.imem_req),    32'd0);
        check("rst_valid",   32'(bus.instr_valid), 32'd0);
        check("rst_pc",      pc,                   32'h0000_0000);
        check("rst_retired", retired,              32'd0);
        check("rst_instr",   bus.instr,            32'd0);
        check("rst_state",   32'(estado),          32'(ST_REQ));
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        check("late_ack_instr", bus.instr,            32'd0);
        check("late_ack_valid", 32'(bus.instr_valid), 32'd0);
        check("late_ack_req",   32'(bus.imem_req),    32'd0);
        rst          = 1'b0;
        bus.imem_ack = 1'b0;
        exp_q.delete();
        m_pc  = 32'h0000_0000;
        m_ret = 32'd0;
    endtask

    task automatic calc_vec(input string tag, input logic [31:0] p, input logic [31:0] w,
                            input logic b, input logic j, input logic z);
        c_pc = p; c_instr = w; c_br = b; c_jp = j; c_z = z;
        #1;
        check(tag, c_next, model_next(p, w, b, j, z));
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- main sequence ----------------
    initial begin
        n_checks = 0;
        n_errors = 0;
        m_pc     = 32'h0000_0000;
        m_ret    = 32'd0;
        rst             = 1'b1;
        bus.imem_ack    = 1'b1;
        bus.imem_rdata  = 32'hCAFE_F00D;
        bus.instr_ready = 1'b1;
        bus.branch      = 1'b0;
        bus.jump        = 1'b0;
        bus.zero        = 1'b0;
        c_pc = 32'd0; c_instr = 32'd0; c_br = 1'b0; c_jp = 1'b0; c_z = 1'b0;

        // Reset values, with an ack present that must not be captured
        repeat (3) @(negedge clk);
        check("reset_req",     32'(bus.imem_req),    32'd0);
        check("reset_valid",   32'(bus.instr_valid), 32'd0);
        check("reset_pc",      pc,                   32'h0000_0000);
        check("reset_instr",   bus.instr,            32'd0);
        check("reset_retired", retired,              32'd0);
        check("reset_state",   32'(estado),          32'(ST_REQ));
        rst          = 1'b0;
        bus.imem_ack = 1'b0;

        // Sequential fetch at full rate: addresses 0,4,8,12
        for (int k = 0; k < 4; k++) fetch_one(0, 0, $urandom() & 32'h03FF_FFFF, 1'b0, 1'b0, 1'b0);

        // Taken BEQ at 0x10 -> 0x20 (retired=4 checked on entry)
        fetch_one(0, 0, 32'h1000_0003, 1'b1, 1'b0, 1'b1);
        // Backward branch to itself at 0x20
        fetch_one(0, 0, 32'h1000_FFFF, 1'b1, 1'b0, 1'b1);
        // Branch not taken at 0x20 -> 0x24
        fetch_one(0, 0, 32'h1000_0003, 1'b1, 1'b0, 1'b0);
        // Jump with branch also asserted: jump wins -> 0x100
        fetch_one(0, 0, 32'h0800_0040, 1'b1, 1'b1, 1'b1);

        // Stalls: ack 5 cycles late, ready low 3 cycles
        fetch_one(5, 3, $urandom(), 1'b0, 1'b0, 1'b0);

        // Randomized fetches
        for (int k = 0; k < 40; k++) begin
            fetch_one($urandom_range(0, 3), $urandom_range(0, 3), $urandom(),
                      1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)));
        end

        // Reset while awaiting ack, then resume from reset PC
        reset_in_req();
        fetch_one(1, 1, $urandom(), 1'b0, 1'b0, 1'b0);
        fetch_one(0, 0, 32'h1000_0002, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        m_pc = exp_q.pop_front();
        check("final_addr", bus.imem_addr, m_pc);
        check("final_retired", retired, m_ret);

        // Next-PC block: spec corner cases and random vectors
        calc_vec("calc_jump_hi", 32'h4000_0000, 32'h0800_0040, 1'b1, 1'b1, 1'b1);
        check("calc_jump_hi_abs", c_next, 32'h4000_0100);
        calc_vec("calc_wrap", 32'hFFFF_FFFC, $urandom(), 1'b0, 1'b0, 1'b1);
        check("calc_wrap_abs", c_next, 32'h0000_0000);
        calc_vec("calc_back", 32'h0000_0020, 32'h1000_FFFF, 1'b1, 1'b0, 1'b1);
        check("calc_back_abs", c_next, 32'h0000_0020);
        for (int k = 0; k < 20; k++) begin
            calc_vec("calc_rand", $urandom() & 32'hFFFF_FFFC, $urandom(),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
